// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: opcodes, the fetch FSM state type, the fetch
// buffer entry layout and HALT decode.
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // One buffered fetch: the instruction word and the PC it came from.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    // HALT is encoded as JALR with a non-zero immediate field.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:13] == OP_JALR) && (instr[6:0] != 7'd0);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries.
// Ports: push/push_entry write at the tail, pop advances the head, flush
// empties the buffer (wins over push/pop), count is the occupancy, valid is
// high when non-empty, head is the oldest entry (read straight from storage).
module fetch_buffer
    import risc16_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          valid,
    output fetch_entry_t  head
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_next;

    // Occupancy after this cycle's push/pop; simultaneous push+pop holds it.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            valid <= (count_next != '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// RiSC-16 instruction fetch controller. Owns the PC, drives the
// combinational instruction memory, buffers fetched words and hands them to
// decode over valid/ready. Redirects flush the buffer; a fetched HALT stops
// fetching until a redirect arrives.
// Ports: start (leave IDLE), imem_addr/imem_data (memory), redirect_valid/
// redirect_pc (PC change), out_valid/out_ready/out_instr/out_pc (decode
// handshake), halted/busy (FSM status).
module fetch_sequencer
    import risc16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [15:0]   pc_q;
    logic [15:0]   pc_d;
    logic [CW-1:0] buf_count;
    logic          buf_valid;
    fetch_entry_t  buf_head;
    fetch_entry_t  push_entry;
    logic          redirect_act;
    logic          do_push;
    logic          do_pop;

    // Redirect beats push and pop; IDLE ignores redirects.
    assign redirect_act = redirect_valid && (state_q != IDLE);
    assign do_pop       = buf_valid && out_ready && !redirect_valid;
    assign do_push      = (state_q == FETCH) && !redirect_valid &&
                          ((buf_count < CW'(DEPTH)) || do_pop);
    assign push_entry   = '{pc: pc_q, instr: imem_data};

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (do_push),
        .push_entry (push_entry),
        .pop        (do_pop),
        .flush      (redirect_act),
        .count      (buf_count),
        .valid      (buf_valid),
        .head       (buf_head)
    );

    // Next state and next PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (do_push) begin
                    pc_d = pc_q + 16'd1;
                    if (is_halt(imem_data)) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                // The HALT was on a wrong path if anyone redirects us.
                if (redirect_valid) begin
                    state_d = FETCH;
                    pc_d    = redirect_pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy    <= (state_d == FETCH);
            halted  <= (state_d == HALTED);
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = buf_valid;
    assign out_instr = buf_head.instr;
    assign out_pc    = buf_head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_ready;

    logic [15:0] imem_addr, imem_data, out_instr, out_pc;
    logic        out_valid, halted, busy;
    logic [15:0] imem_addr2, imem_data2, out_instr2, out_pc2;
    logic        out_valid2, halted2, busy2;

    logic [15:0] mem [65536];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: spec-level state, PC and an ordered queue of {pc,instr}.
    int          m_state;   // 0 idle, 1 fetching, 2 halted
    logic [15:0] m_pc;
    logic [31:0] m_q [$];

    assign imem_data  = mem[imem_addr];
    assign imem_data2 = mem[imem_addr2];

    fetch_sequencer #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .busy(busy)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFE), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_pc(out_pc2),
        .halted(halted2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit word_is_halt(input logic [15:0] w);
        return ((w >> 13) == 16'd7) && ((w % 16'd128) != 16'd0);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 16'h0000;
        m_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit pop, push;
        if (redirect_valid && m_state != 0) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_state = 1;
        end else begin
            pop  = (m_q.size() != 0) && out_ready;
            push = (m_state == 1) && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, mem[m_pc]});
                if (word_is_halt(mem[m_pc])) m_state = 2;
                m_pc = m_pc + 16'd1;
            end
            if (m_state == 0 && start) m_state = 1;
        end
    endtask

    task automatic compare_all();
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("out_pc", 32'(out_pc), 32'(m_q[0][31:16]));
            check("out_instr", 32'(out_instr), 32'(m_q[0][15:0]));
        end
        check("busy", 32'(busy), 32'(m_state == 1));
        check("halted", 32'(halted), 32'(m_state == 2));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        compare_all();
        check("rst_out_instr", 32'(out_instr), 32'h0);
        check("rst_out_pc", 32'(out_pc), 32'h0);
        check("rst_wrap_addr", 32'(imem_addr2), 32'h0000FFFE);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] wexp [4];
        logic [15:0] seen [$];

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111) w[15] = 1'b0;
            mem[i] = w;
        end
        for (int i = 0; i < 4; i++) mem[i] = 16'h1111 * 16'(i + 1);

        // Streaming at full rate.
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        check("s1_early_valid", 32'(out_valid), 32'h0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("s1_valid", 32'(out_valid), 32'h1);
            check("s1_pc", 32'(out_pc), 32'(i));
            check("s1_instr", 32'(out_instr), 32'(16'h1111 * 16'(i + 1)));
            cycle();
        end

        // Backpressure fills the buffer then resumes.
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        check("bp_addr", 32'(imem_addr), 32'h2);
        check("bp_head", 32'(out_pc), 32'h0);
        out_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            cycle();
            check("bp_resume_pc", 32'(out_pc), 32'(i));
        end

        // Redirect while full.
        out_ready = 1'b0;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        cycle();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("rd_valid", 32'(out_valid), 32'h0);
        check("rd_addr", 32'(imem_addr), 32'h40);
        cycle();
        check("rd_valid2", 32'(out_valid), 32'h1);
        check("rd_pc", 32'(out_pc), 32'h40);

        // HALT at address 5, then a redirect out of HALTED.
        mem[5] = 16'hE001;
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (out_valid) seen.push_back(out_pc);
        end
        check("halt_count", 32'(seen.size()), 32'd6);
        for (int i = 0; i < seen.size(); i++) check("halt_seq", 32'(seen[i]), 32'(i));
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_addr", 32'(imem_addr), 32'h6);
        check("halt_nvalid", 32'(out_valid), 32'h0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("halt_ign_start", 32'(busy), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        cycle();
        redirect_valid = 1'b0;
        check("halt_busy", 32'(busy), 32'h1);
        cycle();
        check("halt_resume_pc", 32'(out_pc), 32'h10);

        // PC wrap on the RESET_PC = FFFE instance.
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("wrap_valid", 32'(out_valid2), 32'h1);
            check("wrap_pc", 32'(out_pc2), 32'(wexp[i]));
            check("wrap_instr", 32'(out_instr2), 32'(mem[wexp[i]]));
            cycle();
        end

        // Asynchronous reset with a full buffer.
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        check("ar_full", 32'(out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_addr", 32'(imem_addr), 32'h0);
        check("ar_wrap_addr", 32'(imem_addr2), 32'h0000FFFE);
        do_reset();

        // Randomized traffic with scattered HALTs.
        for (int i = 0; i < 3000; i++) begin
            w = 16'($urandom_range(0, 65535));
            mem[w] = 16'hE000 | 16'($urandom_range(1, 127));
        end
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start          = ($urandom_range(0, 9) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 16'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
